// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage of a single-cycle MIPS datapath.
//   - ALU-control decode: funct (inst) + ALUop -> 4-bit operation code
//   - W-bit ALU with zero (zr) and signed-overflow (ovf) flags
//   - branch-target adder: result = proxEnd + desl
// All datapath outputs are combinational, so beq resolves in the same cycle.
// A capture register (aluOut_q/zr_q/ovf_q) holds the last ALU result and flags
// for debug and monitoring.
//
// Ports:
//   clock, reset_n          clock; async active-low reset (capture register only)
//   inst[5:0], ALUop[1:0]   funct field and operation class from main control
//   dadosLe1, muxOut        ALU operands A and B
//   proxEnd, desl           PC+4 and the shifted sign-extended offset
//   controlOut              decoded ALU operation code
//   aluOut, zr, ovf         combinational ALU result and flags
//   result                  branch target
//   aluOut_q, zr_q, ovf_q   registered copies of aluOut, zr and ovf
module alu_exec_unit #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [5:0]   inst,
  input  logic [1:0]   ALUop,
  input  logic [W-1:0] dadosLe1,
  input  logic [W-1:0] muxOut,
  input  logic [W-1:0] proxEnd,
  input  logic [W-1:0] desl,
  output logic [3:0]   controlOut,
  output logic [W-1:0] aluOut,
  output logic         zr,
  output logic         ovf,
  output logic [W-1:0] result,
  output logic [W-1:0] aluOut_q,
  output logic         zr_q,
  output logic         ovf_q
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_INV = 4'b1111;

  // ALU-control decode
  always_comb begin
    controlOut = OP_ADD;
    case (ALUop)
      2'b00: controlOut = OP_ADD;   // load/store address
      2'b01: controlOut = OP_SUB;   // beq compare
      2'b10: begin
        case (inst)
          6'b100000: controlOut = OP_ADD;
          6'b100010: controlOut = OP_SUB;
          6'b100100: controlOut = OP_AND;
          6'b100101: controlOut = OP_OR;
          6'b101010: controlOut = OP_SLT;
          6'b100111: controlOut = OP_NOR;
          default:   controlOut = OP_INV;
        endcase
      end
      default: controlOut = OP_ADD;
    endcase
  end

  // ALU datapath
  logic [W-1:0] sum, diff;
  logic         slt;
  logic         a_s, b_s;

  assign sum  = dadosLe1 + muxOut;
  assign diff = dadosLe1 - muxOut;
  // Direct signed compare: stays correct when A-B would overflow.
  assign slt  = $signed(dadosLe1) < $signed(muxOut);
  assign a_s  = dadosLe1[W-1];
  assign b_s  = muxOut[W-1];

  always_comb begin
    aluOut = '0;
    ovf    = 1'b0;
    case (controlOut)
      OP_AND: aluOut = dadosLe1 & muxOut;
      OP_OR:  aluOut = dadosLe1 | muxOut;
      OP_ADD: begin
        aluOut = sum;
        ovf    = (a_s == b_s) && (sum[W-1] != a_s);
      end
      OP_SUB: begin
        aluOut = diff;
        ovf    = (a_s != b_s) && (diff[W-1] != a_s);
      end
      OP_SLT: aluOut = {{(W-1){1'b0}}, slt};
      OP_NOR: aluOut = ~(dadosLe1 | muxOut);
      default: begin
        aluOut = '0;
        ovf    = 1'b0;
      end
    endcase
  end

  assign zr = (aluOut == '0);

  // Branch-target adder; carry-out intentionally dropped.
  assign result = proxEnd + desl;

  // Debug capture register
  logic [W-1:0] alu_d;
  logic         zr_d, ovf_d;

  assign alu_d = aluOut;
  assign zr_d  = zr;
  assign ovf_d = ovf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aluOut_q <= '0;
      zr_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      aluOut_q <= alu_d;
      zr_q     <= zr_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed test-plan steps followed by
// randomized operations, checked against a behavioural model that uses wide
// signed arithmetic for results and overflow.
module tb_alu_exec_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  inst = '0;
  logic [1:0]  ALUop = '0;
  logic [31:0] dadosLe1 = '0, muxOut = '0, proxEnd = '0, desl = '0;
  logic [3:0]  controlOut;
  logic [31:0] aluOut, result, aluOut_q;
  logic        zr, ovf, zr_q, ovf_q;

  int checks = 0;
  int errors = 0;

  // expected values of the last applied operation, for the capture check
  logic [31:0] e_alu;
  logic        e_zr, e_ovf;

  alu_exec_unit #(.W(32)) dut (
    .clock(clock), .reset_n(reset_n), .inst(inst), .ALUop(ALUop),
    .dadosLe1(dadosLe1), .muxOut(muxOut), .proxEnd(proxEnd), .desl(desl),
    .controlOut(controlOut), .aluOut(aluOut), .zr(zr), .ovf(ovf),
    .result(result), .aluOut_q(aluOut_q), .zr_q(zr_q), .ovf_q(ovf_q)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: operation table plus 64-bit signed arithmetic.
  task automatic model(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [3:0] c, output logic [31:0] y,
                       output logic z, output logic o);
    longint sa, sb, wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'b01) c = 4'b0110;
    else if (op != 2'b10) c = 4'b0010;
    else if (fn == 6'd32) c = 4'b0010;
    else if (fn == 6'd34) c = 4'b0110;
    else if (fn == 6'd36) c = 4'b0000;
    else if (fn == 6'd37) c = 4'b0001;
    else if (fn == 6'd42) c = 4'b0111;
    else if (fn == 6'd39) c = 4'b1100;
    else c = 4'b1111;
    y = 32'd0;
    o = 1'b0;
    wide = 0;
    if (c == 4'b0010 || c == 4'b0110) begin
      wide = (c == 4'b0010) ? sa + sb : sa - sb;
      y = wide[31:0];
      // overflow iff the true signed result does not fit in 32 bits
      o = (wide != longint'($signed(y)));
    end else if (c == 4'b0000) y = a & b;
    else if (c == 4'b0001) y = a | b;
    else if (c == 4'b1100) y = ~(a | b);
    else if (c == 4'b0111) y = (sa < sb) ? 32'd1 : 32'd0;
    z = (y == 32'd0);
  endtask

  // Drive one operation away from the clock edge and check all combinational outputs.
  task automatic apply(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pe, input logic [31:0] ds);
    logic [3:0]  c;
    logic [31:0] r;
    @(negedge clock);
    ALUop = op; inst = fn; dadosLe1 = a; muxOut = b; proxEnd = pe; desl = ds;
    #1;
    model(op, fn, a, b, c, e_alu, e_zr, e_ovf);
    r = pe + ds;
    chk("controlOut", {28'd0, controlOut}, {28'd0, c});
    chk("aluOut", aluOut, e_alu);
    chk("zr", {31'd0, zr}, {31'd0, e_zr});
    chk("ovf", {31'd0, ovf}, {31'd0, e_ovf});
    chk("result", result, r);
  endtask

  task automatic tick_check();
    @(posedge clock);
    #1;
    chk("aluOut_q", aluOut_q, e_alu);
    chk("zr_q", {31'd0, zr_q}, {31'd0, e_zr});
    chk("ovf_q", {31'd0, ovf_q}, {31'd0, e_ovf});
  endtask

  logic [5:0] fn_tbl [8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0, 6'd63};

  initial begin
    // reset state
    #1;
    chk("rst aluOut_q", aluOut_q, 32'd0);
    chk("rst zr_q", {31'd0, zr_q}, 32'd0);
    chk("rst ovf_q", {31'd0, ovf_q}, 32'd0);
    @(negedge clock);
    #2 reset_n = 1'b1;

    // directed test plan
    apply(2'b10, 6'b100000, 32'd5, 32'd7, 32'd0, 32'd0);
    chk("add5+7", aluOut, 32'd12);
    tick_check();
    chk("cap12", aluOut_q, 32'd12);
    apply(2'b01, 6'b000000, 32'h10, 32'h10, 32'd0, 32'd0);
    chk("beq zr", {31'd0, zr}, 32'd1);
    apply(2'b10, 6'b100010, 32'h8000_0000, 32'd1, 32'd0, 32'd0);
    chk("sub ovf val", aluOut, 32'h7FFF_FFFF);
    chk("sub ovf", {31'd0, ovf}, 32'd1);
    tick_check();
    apply(2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0);
    chk("and", aluOut, 32'h00F0_00F0);
    apply(2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0);
    chk("or", aluOut, 32'hFFF0_FFF0);
    apply(2'b10, 6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0);
    chk("nor", aluOut, 32'h000F_000F);
    apply(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("slt -1<1", aluOut, 32'd1);
    apply(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
    chk("slt 1<-1", aluOut, 32'd0);
    apply(2'b10, 6'b101010, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0);
    chk("slt ovf-case", aluOut, 32'd1);
    apply(2'b10, 6'b000000, 32'd3, 32'd4, 32'd0, 32'd0);
    chk("inv ctrl", {28'd0, controlOut}, 32'hF);
    chk("inv zr", {31'd0, zr}, 32'd1);
    tick_check();
    apply(2'b00, 6'b101010, 32'd1, 32'd2, 32'd0, 32'd0);
    chk("ldst ctrl", {28'd0, controlOut}, 32'h2);
    apply(2'b11, 6'b100010, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("add ovf", {31'd0, ovf}, 32'd1);
    tick_check();
    apply(2'b00, 6'd0, 32'd0, 32'd0, 32'h0000_0004, 32'hFFFF_FFF8);
    chk("br back", result, 32'hFFFF_FFFC);
    apply(2'b00, 6'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8);
    chk("br wrap", result, 32'h0000_0004);

    // asynchronous reset mid-cycle
    apply(2'b10, 6'b100000, 32'd5, 32'd7, 32'd0, 32'd0);
    tick_check();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst aluOut_q", aluOut_q, 32'd0);
    chk("arst zr_q", {31'd0, zr_q}, 32'd0);
    chk("arst ovf_q", {31'd0, ovf_q}, 32'd0);
    chk("arst aluOut", aluOut, 32'd12);
    @(posedge clock);
    #1;
    chk("hold aluOut_q", aluOut_q, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick_check();
    chk("resume", aluOut_q, 32'd12);

    // randomized operations
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000 | $urandom_range(0, 3);
        1: a = 32'h7FFF_FFFF - $urandom_range(0, 3);
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      apply(2'($urandom_range(0, 3)), fn_tbl[$urandom_range(0, 7)], a, b, $urandom, $urandom);
      tick_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage of the single-cycle MIPS datapath. Merges three functions:
  - ALU-control decode (funct + ALUop to a 4-bit operation code);
  - 32-bit ALU with zero and overflow flags;
  - branch-target adder (PC+4 plus the shifted offset).
- All datapath outputs are combinational, so the branch decision (branch & zr) resolves in the same cycle.
- A clocked capture register holds the last ALU result and flags for debug and monitoring.

Parameters:
- W, 32, datapath width in bits for operands, result and adder.

Ports:
- clock  input  1  system clock; capture register updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- inst  input  6  instruction funct field, bits [5:0].
- ALUop  input  2  ALU operation class from main control.
- dadosLe1  input  W  ALU operand A (register read data 1).
- muxOut  input  W  ALU operand B (from the ALUSrc mux).
- proxEnd  input  W  PC+4.
- desl  input  W  sign-extended offset, already shifted left by 2.
- controlOut  output  4  decoded ALU operation code.
- aluOut  output  W  ALU result (combinational).
- zr  output  1  1 when aluOut == 0.
- ovf  output  1  signed overflow for ADD/SUB; 0 for all other operations.
- result  output  W  branch target, proxEnd + desl.
- aluOut_q  output  W  registered aluOut.
- zr_q  output  1  registered zr.
- ovf_q  output  1  registered ovf.

Behaviour:
- ALU-control decode is combinational.

  | ALUop | inst (funct) | controlOut | Operation |
  |---|---|---|---|
  | 00 | any | 0010 | ADD (load/store) |
  | 01 | any | 0110 | SUB (beq) |
  | 10 | 100000 | 0010 | ADD |
  | 10 | 100010 | 0110 | SUB |
  | 10 | 100100 | 0000 | AND |
  | 10 | 100101 | 0001 | OR |
  | 10 | 101010 | 0111 | SLT |
  | 10 | 100111 | 1100 | NOR |
  | 10 | any other funct | 1111 | invalid |
  | 11 | any | 0010 | ADD |

- ALU is combinational, driven by controlOut:
  - 0000 → A & B.
  - 0001 → A | B.
  - 0010 → A + B, modulo 2^W.
  - 0110 → A − B, modulo 2^W.
  - 0111 → 1 if signed(A) < signed(B), else 0; zero-extended to W.
  - 1100 → ~(A | B).
  - Any other code → aluOut = 0.
- zr = (aluOut == 0), evaluated for every operation, including invalid codes (gives zr = 1).
- ovf:
  - ADD: operands share a sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from A.
  - All other operations: 0.
- SLT compares signed values directly, so it is correct even where A−B would overflow.
- Branch adder: result = proxEnd + desl, modulo 2^W. It is independent of ALUop and the ALU. No carry-out is produced.
- Capture register:
  - On each rising clock edge with reset_n high: aluOut_q ← aluOut, zr_q ← zr, ovf_q ← ovf.
  - reset_n low forces aluOut_q = 0, zr_q = 0, ovf_q = 0 immediately, with no clock needed, and holds them while low.
  - First capture occurs on the first rising edge after reset_n deasserts.
- Combinational outputs are never affected by reset_n; they follow their inputs at all times.
- No X propagation: every case statement has a default.

Test Plan:
- ALUop=10, inst=100000, A=5, B=7 → controlOut=0010, aluOut=12, zr=0, ovf=0; aluOut_q=12 after the next rising edge.
- ALUop=01, A=B=0x0000_0010 → controlOut=0110, aluOut=0, zr=1. ALUop=10, inst=100010, A=0x8000_0000, B=1 → aluOut=0x7FFF_FFFF, ovf=1.
- ALUop=10, A=0xF0F0_F0F0, B=0x0FF0_0FF0:
  - inst=100100 → 0x00F0_00F0.
  - inst=100101 → 0xFFF0_FFF0.
  - inst=100111 → 0x000F_000F.
- ALUop=10, inst=101010:
  - A=0xFFFF_FFFF, B=1 → aluOut=1.
  - A=1, B=0xFFFF_FFFF → aluOut=0.
- ALUop=10, inst=000000 → controlOut=1111, aluOut=0, zr=1. ALUop=00 with inst=101010 → controlOut=0010 (funct ignored).
- Branch adder:
  - proxEnd=0x0000_0004, desl=0xFFFF_FFF8 → result=0xFFFF_FFFC.
  - proxEnd=0xFFFF_FFFC, desl=8 → result=0x0000_0004.
- Reset:
  - Pulse reset_n low mid-cycle after capturing a nonzero value → aluOut_q, zr_q, ovf_q go to 0 before any clock edge.
  - aluOut is unaffected.
  - Capture resumes on the first rising edge after release.
